// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream between a bitstream source and the configuration chain loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, word_data, input word_ready);
  modport slave  (input word_valid, word_data, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first into a CLB column configuration chain and
// folds the bits leaving the chain tail into a parity of the previous configuration.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting words and shifting the chain
// DONE  | CHAIN_LEN bits shifted; count and parity held
// ERROR | word stream starved for TIMEOUT stall cycles
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 abort,
  ccff_chain_loader_if.slave   word,
  output logic                 ccff_head,
  output logic                 chain_clk_en,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     bit_count,
  output logic                 tail_parity
);
  localparam int BL_W = $clog2(WORD_W + 1);
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [BL_W-1:0]   bits_left;
  logic [TO_W-1:0]   starve_left;
  logic              head_q;
  logic              room, accept, stall, last_bit, start_ok;

  // Only ask for a word when the chain still has room for at least one of its bits.
  assign room     = ({1'b0, bit_count} + (CNT_W+1)'(bits_left)) < (CNT_W+1)'(CHAIN_LEN);
  assign accept   = word.word_valid & word.word_ready;
  assign stall    = (state == LOAD) && (bits_left == '0) && !accept && !abort;
  assign last_bit = chain_clk_en && (bit_count == CNT_W'(CHAIN_LEN - 1));
  assign start_ok = start && (state != LOAD);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    word.word_ready = 1'b0;
    chain_clk_en    = 1'b0;
    ccff_head       = head_q;
    busy            = 1'b0;
    done            = 1'b0;
    error           = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        busy            = 1'b1;
        chain_clk_en    = (bits_left != '0) && !abort;
        word.word_ready = (bits_left <= BL_W'(1)) && room && !abort;
        if (bits_left != '0) ccff_head = shreg[WORD_W-1];
        if (last_bit)                           state_nxt = DONE;
        else if (stall && starve_left == '0)    state_nxt = ERROR;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shreg       <= '0;
      bits_left   <= '0;
      starve_left <= '0;
      head_q      <= 1'b0;
      bit_count   <= '0;
      tail_parity <= 1'b0;
    end else if (abort) begin
      shreg       <= '0;
      bits_left   <= '0;
      starve_left <= TO_W'(TIMEOUT - 1);
      head_q      <= 1'b0;
      bit_count   <= '0;
      tail_parity <= 1'b0;
    end else if (start_ok) begin
      shreg       <= '0;
      bits_left   <= '0;
      starve_left <= TO_W'(TIMEOUT - 1);
      bit_count   <= '0;
      tail_parity <= 1'b0;
    end else if (state == LOAD) begin
      head_q <= ccff_head;
      if (chain_clk_en) begin
        bit_count   <= bit_count + 1'b1;
        tail_parity <= tail_parity ^ ccff_tail;
      end
      if (accept) begin
        shreg       <= word.word_data;
        bits_left   <= BL_W'(WORD_W);
        starve_left <= TO_W'(TIMEOUT - 1);
      end else if (last_bit) begin
        bits_left <= '0;  // excess bits of the final word are dropped
      end else if (chain_clk_en) begin
        shreg     <= shreg << 1;
        bits_left <= bits_left - 1'b1;
      end else if (stall && starve_left != '0) begin
        starve_left <= starve_left - 1'b1;
      end
    end
  end
endmodule
